mem_arbiter: RTL

- Sits between the IF stage, the MEM stage and the byte-serial memory controller (memctrl).
- Accepts one outstanding request per requester, grants exactly one transaction at a time to memctrl, holds it stable until completion, and routes done/data back to the owner.
- MEM has priority, with an IF anti-starvation cap.
- Handles IF flush by discarding the in-flight fetch result.

---
 rtl/mem_defs_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_defs_pkg.sv
// Shared definitions for the memory arbiter slice: size codes, owner and arbiter state encodings.
package mem_defs_pkg;

  localparam int unsigned SZ_W = 2;

  typedef logic [SZ_W-1:0] size_t;

  localparam size_t SZ_NONE = 2'b00;
  localparam size_t SZ_BYTE = 2'b01;
  localparam size_t SZ_HALF = 2'b10;
  localparam size_t SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: MEM priority with an IF anti-starvation cap, plus the
// streak value to load if the pick is granted.
module mem_arb_pick #(
  parameter int unsigned MEM_STREAK_MAX = 4,
  parameter int unsigned STREAK_W       = $clog2(MEM_STREAK_MAX + 1)
) (
  input  logic                if_pend,
  input  logic                mem_pend,
  input  logic [STREAK_W-1:0] streak,
  output logic                pick_if_c,
  output logic                pick_mem_c,
  output logic [STREAK_W-1:0] streak_nxt_c
);

  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MEM_STREAK_MAX);

  logic cap_hit;

  assign cap_hit    = if_pend && (streak == STREAK_CAP);
  assign pick_mem_c = mem_pend && !cap_hit;
  assign pick_if_c  = if_pend && !pick_mem_c;

  // Streak counts MEM wins that made a waiting IF wait longer
  always_comb begin
    streak_nxt_c = streak;
    if (pick_mem_c) begin
      if (!if_pend) begin
        streak_nxt_c = '0;
      end else if (streak != STREAK_CAP) begin
        streak_nxt_c = streak + STREAK_W'(1);
      end
    end else if (pick_if_c) begin
      streak_nxt_c = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto the single byte-serial memctrl port,
// holding one granted transaction stable until done and routing the result to its owner.
module mem_arbiter
  import mem_defs_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic [1:0]        mem_re_i,
  input  logic              mem_rsign_i,
  input  logic [1:0]        mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              ctl_if_re_o,
  output logic [ADDR_W-1:0] ctl_if_addr_o,
  output logic [1:0]        ctl_mem_re_o,
  output logic              ctl_mem_rsign_o,
  output logic [1:0]        ctl_mem_we_o,
  output logic [ADDR_W-1:0] ctl_mem_addr_o,
  output logic [DATA_W-1:0] ctl_mem_wdata_o,
  input  logic              ctl_busy_i,
  input  logic [DATA_W-1:0] ctl_data_i,
  input  logic              ctl_done_i
);

  localparam int unsigned STREAK_W = $clog2(MEM_STREAK_MAX + 1);

  arb_state_e          state, state_nxt;
  owner_e              owner, owner_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt, streak_pick;
  logic                discard, discard_nxt;
  logic [ADDR_W-1:0]   req_addr, req_addr_nxt;
  size_t               req_size, req_size_nxt;
  logic                req_store, req_store_nxt;
  logic                req_rsign, req_rsign_nxt;
  logic [DATA_W-1:0]   req_wdata, req_wdata_nxt;
  logic [DATA_W-1:0]   if_data_q, mem_data_q;

  logic mem_pend, if_pend, pick_if, pick_mem;
  logic arb_en, done_en, grant;
  logic ctl_active, ctl_if_sel, ctl_mem_sel;

  assign mem_pend = (mem_re_i != SZ_NONE) || (mem_we_i != SZ_NONE);
  assign if_pend  = if_req_i && !if_flush_i;

  mem_arb_pick #(
    .MEM_STREAK_MAX(MEM_STREAK_MAX),
    .STREAK_W      (STREAK_W)
  ) u_pick (
    .if_pend     (if_pend),
    .mem_pend    (mem_pend),
    .streak      (streak),
    .pick_if_c   (pick_if),
    .pick_mem_c  (pick_mem),
    .streak_nxt_c(streak_pick)
  );

  // Re-arbitrate during the done cycle so the next grant follows back-to-back
  assign arb_en  = rdy_i && ((state == ST_IDLE) || ctl_done_i);
  assign done_en = rdy_i && (state == ST_BUSY) && ctl_done_i;
  assign grant   = arb_en && (pick_if || pick_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      streak    <= '0;
      discard   <= 1'b0;
      req_addr  <= '0;
      req_size  <= SZ_NONE;
      req_store <= 1'b0;
      req_rsign <= 1'b0;
      req_wdata <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      streak    <= streak_nxt;
      discard   <= discard_nxt;
      req_addr  <= req_addr_nxt;
      req_size  <= req_size_nxt;
      req_store <= req_store_nxt;
      req_rsign <= req_rsign_nxt;
      req_wdata <= req_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    streak_nxt    = streak;
    discard_nxt   = discard;
    req_addr_nxt  = req_addr;
    req_size_nxt  = req_size;
    req_store_nxt = req_store;
    req_rsign_nxt = req_rsign;
    req_wdata_nxt = req_wdata;
    if (rdy_i) begin
      if ((state == ST_BUSY) && (owner == OWN_IF) && if_flush_i) begin
        discard_nxt = 1'b1;
      end
      if (done_en) begin
        discard_nxt = 1'b0;
        state_nxt   = ST_IDLE;
        owner_nxt   = OWN_NONE;
      end
      // A store wins over a simultaneous load code, matching memctrl
      if (arb_en && pick_mem) begin
        state_nxt     = ST_BUSY;
        owner_nxt     = OWN_MEM;
        streak_nxt    = streak_pick;
        req_addr_nxt  = mem_addr_i;
        req_store_nxt = (mem_we_i != SZ_NONE);
        req_size_nxt  = (mem_we_i != SZ_NONE) ? size_t'(mem_we_i) : size_t'(mem_re_i);
        req_rsign_nxt = mem_rsign_i;
        req_wdata_nxt = mem_wdata_i;
      end else if (arb_en && pick_if) begin
        state_nxt     = ST_BUSY;
        owner_nxt     = OWN_IF;
        streak_nxt    = streak_pick;
        req_addr_nxt  = if_addr_i;
        req_store_nxt = 1'b0;
        req_size_nxt  = SZ_WORD;
        req_rsign_nxt = 1'b0;
        req_wdata_nxt = '0;
      end
    end
  end

  // Completion pulses coincide with memctrl done; data holds between pulses
  assign if_valid_o = done_en && (owner == OWN_IF) && !discard && !if_flush_i;
  assign mem_done_o = done_en && (owner == OWN_MEM);
  assign if_data_o  = if_valid_o ? ctl_data_i : if_data_q;
  assign mem_data_o = mem_done_o ? ctl_data_i : mem_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      if (if_valid_o) if_data_q  <= ctl_data_i;
      if (mem_done_o) mem_data_q <= ctl_data_i;
    end
  end

  // Request lines drop in the done cycle so memctrl cannot relaunch the finished access
  assign ctl_active  = (state == ST_BUSY) && !ctl_done_i;
  assign ctl_if_sel  = ctl_active && (owner == OWN_IF);
  assign ctl_mem_sel = ctl_active && (owner == OWN_MEM);

  assign ctl_if_re_o     = ctl_if_sel;
  assign ctl_if_addr_o   = ctl_if_sel ? req_addr : '0;
  assign ctl_mem_re_o    = (ctl_mem_sel && !req_store) ? req_size : SZ_NONE;
  assign ctl_mem_we_o    = (ctl_mem_sel && req_store) ? req_size : SZ_NONE;
  assign ctl_mem_rsign_o = ctl_mem_sel && req_rsign;
  assign ctl_mem_addr_o  = ctl_mem_sel ? req_addr : '0;
  assign ctl_mem_wdata_o = ctl_mem_sel ? req_wdata : '0;

  a_no_grant_while_busy : assert property (@(posedge clk) disable iff (!rst) !(grant && ctl_busy_i));

endmodule
